// File: rtl/seg_pkg.sv
// Shared constants and types for the two-digit seven-segment display driver.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Anode enables, active-low; an[3:2] are never driven on.
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Which digit position the scan is currently driving.
    typedef enum logic {
        SEL_ONES = 1'b0,
        SEL_TENS = 1'b1
    } digit_sel_e;

    // One BCD digit pair, tens and ones.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } digits_t;

    // Everything sampled from the countdown block in one word.
    typedef struct packed {
        logic    active;
        digits_t digits;
    } in_sample_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes above 9 show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Decode one digit to its active-low cathode pattern.
    always_comb begin
        unique case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Two-digit multiplexed seven-segment driver for a countdown timer.
// Inputs are synchronized, sampled once per frame so both digits always come
// from the same snapshot, and the display blinks once the countdown expires.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] s10,
    input  logic [3:0] s1,
    input  logic       countDownActive,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    in_sample_t          raw;
    in_sample_t          sync_meta_q;
    in_sample_t          sync_q;
    logic [SCAN_W-1:0]   scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    digit_sel_e          sel_q,       sel_d;
    logic                blink_phase_q, blink_phase_d;
    digits_t             shown_q,     shown_d;
    logic [3:0]          an_q,        an_d;
    logic [6:0]          seg_q,       seg_d;
    logic                scan_wrap;
    logic                blink_wrap;
    logic                expired;
    logic                lead_blank;
    logic [3:0]          cur_digit;
    logic [6:0]          seg_dec;

    assign raw = '{active: countDownActive, digits: '{tens: s10, ones: s1}};

    // Two-flop synchronizer for every input coming from the countdown block.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the two
        // synchronizer stages into one.
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
        end else begin
            sync_meta_q <= raw;
            sync_q      <= sync_meta_q;
        end
    end

    // Next-state for scan/blink timing, digit select and the frame snapshot.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        scan_wrap     = (scan_cnt_q == SCAN_LAST);
        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        scan_cnt_d    = scan_cnt_q + 1'b1;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        sel_d         = sel_q;
        blink_phase_d = blink_phase_q;
        shown_d       = shown_q;

        if (scan_wrap) begin
            scan_cnt_d = '0;
            sel_d      = (sel_q == SEL_ONES) ? SEL_TENS : SEL_ONES;
            // Tens slot ending means a new frame starts: take one snapshot.
            if (sel_q == SEL_TENS) begin
                shown_d = sync_q.digits;
            end
        end

        if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Timing counters, select, blink phase and the displayed snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            sel_q         <= SEL_ONES;
            blink_phase_q <= 1'b0;
            shown_q       <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            sel_q         <= sel_d;
            blink_phase_q <= blink_phase_d;
            shown_q       <= shown_d;
        end
    end

    assign cur_digit = (sel_q == SEL_TENS) ? shown_q.tens : shown_q.ones;

    bcd_to_seg u_bcd_to_seg (
        .digit_i (cur_digit),
        .seg_o   (seg_dec)
    );

    // Anode selection with leading-zero blanking and expiry blinking.
    always_comb begin
        expired    = sync_q.active && (shown_q.tens == 4'd0) && (shown_q.ones == 4'd0);
        lead_blank = (shown_q.tens == 4'd0) && (shown_q.ones != 4'd0);
        an_d       = (sel_q == SEL_TENS) ? AN_TENS : AN_ONES;
        seg_d      = seg_dec;

        if ((sel_q == SEL_TENS) && lead_blank) begin
            an_d = AN_OFF;
        end
        if (expired && blink_phase_q) begin
            an_d = AN_OFF;
        end
    end

    // Output register keeps anode/cathode edges glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule
